// File: rtl/cvp14_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cvp14_mem_responder
// Brief    : CVP14 bus memory responder: fixed-latency reads, writes,
//            backdoor preload port, sticky error flags.
//            Optional macro MEM_RESP_STATS_EN enables the read/write counters.
// Revision : 1.0 - initial release
// ============================================================================
module cvp14_mem_responder #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] WrData,
    output logic [15:0] RdData,
    output logic        RdValid,
    output logic        Busy,
    output logic        AddrErr,
    output logic        ProtErr,
    input  logic        LdEn,
    input  logic [15:0] LdAddr,
    input  logic [15:0] LdData,
    output logic [15:0] RdCount,
    output logic [15:0] WrCount
);

    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        RWAIT = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [15:0] mem [DEPTH];
    logic [15:0] hold;
    logic [15:0] rd_word;
    logic [15:0] done_data;
    logic        rd_done;
    logic        addr_ok, ld_ok;
    logic        rd_req, wr_req, rd_accept;

    assign addr_ok   = 32'(Addr) < 32'(DEPTH);
    assign ld_ok     = 32'(LdAddr) < 32'(DEPTH);
    assign rd_req    = RD & ~WR;
    assign wr_req    = WR & ~RD;
    assign rd_accept = rd_req & (state == IDLE);
    assign rd_word   = addr_ok ? mem[Addr[AW-1:0]] : 16'h0000;
    assign Busy      = (state == RWAIT);

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rd_done   = 1'b0;
        done_data = hold;
        case (state)
            IDLE: begin
                if (rd_accept) begin
                    if (READ_LAT == 1) begin
                        rd_done   = 1'b1;
                        done_data = rd_word;
                    end else begin
                        state_nx = RWAIT;
                        cnt_nx   = LAT_M1;
                    end
                end
            end
            RWAIT: begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nx = IDLE;
                    rd_done  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Hold captures the array at acceptance, so later writes cannot leak in.
    always_ff @(posedge Clk1) begin
        if (rd_accept) begin
            hold <= rd_word;
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            RdData  <= 16'h0000;
            RdValid <= 1'b0;
            AddrErr <= 1'b0;
            ProtErr <= 1'b0;
        end else begin
            RdValid <= rd_done;
            if (rd_done) begin
                RdData <= done_data;
            end
            if ((rd_accept | wr_req) & ~addr_ok) begin
                AddrErr <= 1'b1;
            end
            if ((RD & WR) | (RD & (state == RWAIT))) begin
                ProtErr <= 1'b1;
            end
        end
    end

    // Backdoor write is issued last so it wins an address collision.
    always_ff @(posedge Clk1) begin
        if (wr_req && addr_ok) begin
            mem[Addr[AW-1:0]] <= WrData;
        end
        if (LdEn && ld_ok) begin
            mem[LdAddr[AW-1:0]] <= LdData;
        end
    end

`ifdef MEM_RESP_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            rd_cnt <= 16'h0000;
            wr_cnt <= 16'h0000;
        end else begin
            if (rd_done && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'h0001;
            end
            if (wr_req && addr_ok && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'h0001;
            end
        end
    end

    assign RdCount = rd_cnt;
    assign WrCount = wr_cnt;
`else
    assign RdCount = 16'h0000;
    assign WrCount = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/cvp14_mem_responder.md
Name: cvp14_mem_responder

Overview:
Memory-side responder for the CVP14 processor bus. It answers the processor's RD/WR strobes on Addr, stores processor write data and returns read data after a fixed latency. It sits between the processor core and the word-addressed data/instruction store. It also provides a backdoor load port so benches can preload programs.

Parameters:
DEPTH, 1024, number of 16-bit words; legal range 1..65536; valid addresses are 0..DEPTH-1.
READ_LAT, 2, cycles from RD sample to data valid; legal range 1..8.

Ports:
Clk1  input  1  bus clock; all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
Addr  input  16  word address from processor.
RD  input  1  read strobe, sampled each posedge.
WR  input  1  write strobe, sampled each posedge.
WrData  input  16  write data (processor DataOut).
RdData  output  16  read data (to processor DataIn).
RdValid  output  1  one-cycle pulse: RdData just updated.
Busy  output  1  read in flight; new RD is not accepted.
AddrErr  output  1  sticky: out-of-range access seen.
ProtErr  output  1  sticky: RD&WR together, or RD while Busy.
LdEn  input  1  backdoor write enable.
LdAddr  input  16  backdoor address.
LdData  input  16  backdoor data.
RdCount  output  16  reads completed (see Optional Feature).
WrCount  output  16  writes performed (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; latency counter is cleared.
  - RdData=0, RdValid=0, Busy=0, AddrErr=0, ProtErr=0, RdCount=0, WrCount=0.
  - Array contents are NOT cleared.
  - A read pending at reset is dropped: no RdValid.
- FSM states: IDLE, RWAIT.
- IDLE:
  - RD=1, WR=0: array[Addr] is read at this edge into a hold register; counter=READ_LAT-1.
    - If READ_LAT==1: RdData/RdValid update at this same edge; stay IDLE.
    - Else: go to RWAIT with Busy=1.
  - Out-of-range read (Addr>=DEPTH): hold value is 16'h0000 and AddrErr is set. Timing is otherwise identical.
- RWAIT:
  - Counter decrements each edge.
  - On the edge where it reaches 0: RdData<=hold, RdValid=1 for one cycle, Busy=0, return to IDLE.
  - Net timing: RD sampled at edge N gives RdData/RdValid valid after edge N+READ_LAT-1. In cycle terms, data is visible READ_LAT cycles after RD was presented.
- RD while Busy: ignored, ProtErr set, in-flight read unaffected.
- RdData holds its value until the next read completes.
- Writes:
  - WR=1, RD=0 with Addr<DEPTH: array[Addr]<=WrData at this edge, in any state.
  - A write accepted while a read is in flight does not alter the already-captured hold data (read-before-write).
  - Out-of-range write: dropped, AddrErr set.
- RD=1 and WR=1 together: neither operation is performed; ProtErr set.
- Backdoor port:
  - LdEn=1 with LdAddr<DEPTH writes LdData at the edge, in any state.
  - If LdEn and a bus write target the same address in the same cycle, LdData wins.
  - Out-of-range LdAddr is dropped; the error flags are not affected.
- Sticky flags clear only on Reset.

Optional Feature:
MEM_RESP_STATS_EN
- Defined:
  - RdCount increments when a read completes (RdValid pulse), including out-of-range reads.
  - WrCount increments on each performed bus write (backdoor writes are not counted).
  - Both counters saturate at 16'hFFFF.
- Undefined: RdCount and WrCount are tied to 0 and no counter logic is present.

Test Plan:
- Preload array[0x0010]=0x1234 via LdEn; RD with Addr=0x0010 at edge N, READ_LAT=2 -> Busy=1 for one cycle; RdValid pulses once after edge N+1 with RdData=0x1234; RdData stays 0x1234 afterwards.
- WR Addr=0x0020 WrData=0xBEEF, then RD 0x0020 -> RdData=0xBEEF. With READ_LAT=1, RdValid comes on the same edge as the RD sample.
- RD 0x0030 (holds 0x1111), then WR 0x0030=0x2222 while Busy -> RdData=0x1111; a following read of 0x0030 returns 0x2222.
- RD Addr=0x0400 with DEPTH=1024 -> RdData=0x0000, RdValid pulses, AddrErr=1 and stays 1 until Reset. WR 0xFFFF -> array unchanged.
- RD and WR together -> ProtErr=1, no RdValid, no write. RD while Busy -> ProtErr=1, original read completes correctly.
- Reset asserted while in RWAIT -> no RdValid, all outputs 0, preloaded data still readable afterwards. With MEM_RESP_STATS_EN, 3 reads + 2 writes give RdCount=3 and WrCount=2.
